imem_loader: RTL and testbench

Program loader: the write side of the instruction-memory interface the core reads through its program counter. It accepts a byte stream over a valid/ready handshake, frames it as length header, little-endian 32-bit instruction words and an optional checksum, and issues one word write per instruction into instruction memory at byte addresses 0, 4, 8, …. While a load is in progress it holds the core in reset, and it releases the core only after a clean load.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/loader_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CKS_W      = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned LEN_W      = HDR_BYTES * BYTE_W;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/loader_byte_packer.sv
// Little-endian byte-to-word assembler: first pushed byte lands in [7:0].
module loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] word_q;

  // Byte index and assembly register; index wraps after the last byte of a word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (push_i) begin
      word_q[{idx_q, 3'b000} +: BYTE_W] <= byte_i;
      idx_q                             <= idx_q + IDX_W'(1);
    end
  end

  assign word_o = word_q;
  // High while the next push completes a word.
  assign full_o = (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: frames a byte stream (length, LE words, optional checksum)
// into instruction-memory word writes and holds the core until a clean load.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N  = 20,
  parameter int unsigned AW = $clog2(N) + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t LAST_ST = ST_CHECK;
`else
  localparam loader_state_t LAST_ST = ST_DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [AW-1:0]     addr_q;
  logic [LEN_W-1:0]  hdr_len;
  logic              accept;
  logic              start_ok;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;
  logic              pk_push;

  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign accept   = byte_valid_i && ready_q;
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));
  assign hdr_len  = {byte_i, len_q[7:0]};
  assign pk_push  = (state_q == ST_DATA) && accept;

  loader_byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_ok),
    .push_i (pk_push),
    .byte_i (byte_i),
    .word_o (pk_word),
    .full_o (pk_full)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [CKS_W-1:0] cks_q;

  // Running XOR of payload bytes only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cks_q <= '0;
    end else if (start_ok) begin
      cks_q <= '0;
    end else if (pk_push) begin
      cks_q <= cks_q ^ byte_i;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          if (hdr_len > LEN_W'(N))  state_d = ST_ERR;
          else if (hdr_len == '0)   state_d = LAST_ST;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && pk_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ((cnt_q + LEN_W'(1)) == len_q) ? LAST_ST : ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (byte_i == cks_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    ready_d   = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                (state_d == ST_DATA)   || (state_d == ST_CHECK);
    wr_en_d   = (state_d == ST_WRITE);
    wr_addr_d = '0;
    wr_data_d = '0;
    if (wr_en_d) begin
      wr_addr_d = 32'(addr_q);
      wr_data_d = {byte_i, pk_word[23:0]};
    end
    hold_d    = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Length header, word counter and write address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else if (start_ok) begin
      len_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      if ((state_q == ST_LEN_LO) && accept) len_q[7:0]  <= byte_i;
      if ((state_q == ST_LEN_HI) && accept) len_q[15:8] <= byte_i;
      if (state_q == ST_WRITE) begin
        cnt_q  <= cnt_q + LEN_W'(1);
        addr_q <= addr_q + AW'(WORD_BYTES);
      end
    end
  end

  assign byte_ready_o = ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign core_hold_o  = hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load sessions, write scoreboard,
// plus a mid-session reset sequence.
module tb_imem_loader;

  localparam int N = 20;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  cks;
    int          gap;
    bit          exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        core_hold_o;
  logic        done_o;
  logic        err_o;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;

  imem_loader #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .core_hold_o  (core_hold_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected (addr, data) pair.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      check32("ready_during_write", 32'(byte_ready_o), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 wr_addr_o, wr_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check32("wr_addr", wr_addr_o, mon_e.addr);
        check32("wr_data", wr_data_o, mon_e.data);
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] w0, input logic [31:0] w1, input int i);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return w0 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [7:0] calc_cks(input int len, input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = word_of(w0, w1, i);
      for (int j = 0; j < 4; j++) c = c ^ w[8*j +: 8];
    end
    return c;
  endfunction

  function automatic vec_t mkvec(input int len, input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [7:0] cks, input int gap, input bit exp_done);
    vec_t v;
    v.len = len; v.w0 = w0; v.w1 = w1; v.cks = cks; v.gap = gap; v.exp_done = exp_done;
    return v;
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance (plus gap).
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (byte_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got ready=%0b expected 1 within 50 cycles", byte_ready_o);
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gap);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic push_words(input int len, input logic [31:0] w0, input logic [31:0] w1);
    wr_t e;
    for (int i = 0; i < len; i++) begin
      e.addr = 32'(4 * i);
      e.data = word_of(w0, w1, i);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check32({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    check32({tag, "_wr_addr"}, wr_addr_o, 32'd0);
    check32({tag, "_wr_data"}, wr_data_o, 32'd0);
    check32({tag, "_hold"}, 32'(core_hold_o), 32'd1);
    check32({tag, "_done"}, 32'(done_o), 32'd0);
    check32({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int  t;
    bit  ok_len;
    logic [15:0] l16;
    ok_len = (v.len <= N);
    l16    = 16'(v.len);
    do_start();
    check32({name, "_hold_busy"}, 32'(core_hold_o), 32'd1);
    check32({name, "_done_clr"}, 32'(done_o), 32'd0);
    check32({name, "_err_clr"}, 32'(err_o), 32'd0);
    check32({name, "_ready_hdr"}, 32'(byte_ready_o), 32'd1);
    if (ok_len) push_words(v.len, v.w0, v.w1);
    send_byte(l16[7:0], v.gap);
    send_byte(l16[15:8], v.gap);
    if (ok_len) begin
      for (int i = 0; i < v.len; i++) send_word(word_of(v.w0, v.w1, i), v.gap);
      if (CKS_EN) send_byte(v.cks, v.gap);
    end
    t = 0;
    while (done_o !== 1'b1 && err_o !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_end_timeout: got done=%0b err=%0b expected one set", name, done_o, err_o);
    end
    if (v.exp_done && v.gap == 0)
      check32({name, "_latency"}, 32'(cyc - t0), 32'(2 + 5 * v.len + (CKS_EN ? 1 : 0)));
    check32({name, "_done"}, 32'(done_o), 32'(v.exp_done));
    check32({name, "_err"}, 32'(err_o), 32'(!v.exp_done));
    check32({name, "_hold"}, 32'(core_hold_o), 32'(!v.exp_done));
    check32({name, "_ready_end"}, 32'(byte_ready_o), 32'd0);
    check32({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    vecs.push_back(mkvec(2, 32'h0000_0013, 32'h0010_0093, 8'h90, 0, 1'b1));
    vecs.push_back(mkvec(2, 32'h0000_0013, 32'h0010_0093, 8'h90, 1, 1'b1));
    if (CKS_EN) vecs.push_back(mkvec(2, 32'h0000_0013, 32'h0010_0093, 8'h91, 0, 1'b0));
    vecs.push_back(mkvec(0, 32'h0, 32'h0, 8'h00, 0, 1'b1));
    vecs.push_back(mkvec(21, 32'h0, 32'h0, 8'h00, 0, 1'b0));
    vecs.push_back(mkvec(1, 32'hDEAD_BEEF, 32'h0, 8'h22, 0, 1'b1));
    vecs.push_back(mkvec(N, 32'h1234_5678, 32'h9ABC_DEF0,
                         calc_cks(N, 32'h1234_5678, 32'h9ABC_DEF0), 0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset after the 5th byte abandons the session with no write.
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
    run_vec(vecs[0], "reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
